burst_line_adaptor: RTL and testbench

Parametrised successor to the LLC-to-memory line adaptor. It converts a single line-wide read or write request from the lowest-level cache into a multi-beat burst on the memory port. Writes are now supported, and the adaptor tolerates gaps between memory beats. It sits between the LLC and the burst memory model/controller, and drives exactly one transaction at a time.

---
 rtl/burst_line_adaptor_pkg.sv | 20 ++
 rtl/burst_line_adaptor.sv | 87 ++++++++
 tb/tb_burst_line_adaptor.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_line_adaptor_pkg.sv
// Shared types and defaults for the LLC line to memory burst adaptor.
package burst_line_adaptor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_LINE_W  = 256;
   localparam int DEF_BURST_W = 64;
   localparam int DEF_ADDR_W  = 32;

   // Beat-index width; never zero so the counter stays a legal vector.
   function automatic int beat_idx_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/burst_line_adaptor.sv
// Converts one line-wide LLC read/write into a multi-beat memory burst,
// tolerating idle gaps between memory acknowledges.
module burst_line_adaptor
   import burst_line_adaptor_pkg::*;
#(
   parameter int LINE_W  = DEF_LINE_W,
   parameter int BURST_W = DEF_BURST_W,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = beat_idx_w(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_W / 8) - 1);

   if ((LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
      $error("burst_line_adaptor: LINE_W/BURST_W must be a power of two >= 2");
   end

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] buf_q;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              beat;

   assign accept = (state == IDLE) && (read_i || write_i);
   assign beat   = ((state == READ) || (state == WRITE)) && resp_i;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (write_i) state_nxt = WRITE;
                      else if (read_i) state_nxt = READ;
         READ, WRITE: if (resp_i && cnt == LAST_BEAT) state_nxt = DONE;
         DONE:        state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         addr_q <= '0;
         buf_q  <= '0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q <= address_i & LINE_MASK;
            cnt    <= '0;
            if (write_i) buf_q <= line_i;
         end else if (beat) begin
            // Counter wraps to 0 on the last beat, ready for the next burst.
            cnt <= cnt + 1'b1;
            if (state == READ) buf_q[cnt*BURST_W +: BURST_W] <= burst_i;
         end
      end
   end

   assign read_o    = (state == READ);
   assign write_o   = (state == WRITE);
   assign resp_o    = (state == DONE);
   assign address_o = addr_q;
   assign line_o    = buf_q;

   always_comb begin
      burst_o = '0;
      if (state == WRITE) burst_o = buf_q[cnt*BURST_W +: BURST_W];
   end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor: scoreboard of expected beats/lines
// for the default configuration plus round trips on two other geometries.
module tb_burst_line_adaptor;

   localparam int LW = 256;
   localparam int BW = 64;
   localparam int AW = 32;
   localparam int NB = LW / BW;

   logic          clk = 1'b0;
   logic          reset;
   logic [LW-1:0] line_i, line_o;
   logic [AW-1:0] address_i, address_o;
   logic          read_i, write_i, resp_o;
   logic [BW-1:0] burst_i, burst_o;
   logic          read_o, write_o, resp_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit sweep_go = 1'b0;

   logic [LW-1:0] line_q[$];
   logic [BW-1:0] beat_q[$];
   logic [LW-1:0] exp_line;
   logic [BW-1:0] exp_beat;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   burst_line_adaptor #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_read_beats(input logic [LW-1:0] ln);
      for (int b = 0; b < NB; b++) begin
         resp_i  = 1'b1;
         burst_i = ln[b*BW +: BW];
         tick();
      end
      resp_i  = 1'b0;
      burst_i = '0;
   endtask

   // Scoreboard side: every acknowledged write beat and every completion.
   always @(negedge clk) begin
      if (!reset) begin
         if (write_o && resp_i) begin
            chk("beat_expected", beat_q.size() != 0, 1'b1);
            if (beat_q.size() != 0) begin
               exp_beat = beat_q.pop_front();
               chk("burst_o", burst_o, exp_beat);
            end
         end
         if (resp_o) begin
            chk("resp_expected", line_q.size() != 0, 1'b1);
            if (line_q.size() != 0) begin
               exp_line = line_q.pop_front();
               chk("line_o_at_resp", line_o, exp_line);
            end
         end
      end
   end

   localparam logic [LW-1:0] LN_RD  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [LW-1:0] LN_WR  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
   localparam logic [LW-1:0] LN_W2  = {64'h0F0F_0000_0000_0004, 64'h0F0F_0000_0000_0003,
                                       64'h0F0F_0000_0000_0002, 64'h0F0F_0000_0000_0001};
   localparam logic [LW-1:0] LN_R2  = {64'h5A5A_0000_0000_0004, 64'h5A5A_0000_0000_0003,
                                       64'h5A5A_0000_0000_0002, 64'h5A5A_0000_0000_0001};
   localparam logic [LW-1:0] LN_FR  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h1357_9BDF_0246_8ACE, 64'hDEAD_BEEF_CAFE_F00D};
   localparam logic [LW-1:0] LN_ST  = {64'h8000_0000_0000_0003, 64'h8000_0000_0000_0002,
                                       64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000};

   initial begin
      int t0;
      int pat[7];
      reset = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
      burst_i = '0; resp_i = 1'b0;
      #2;
      chk("rst_read_o", read_o, 1'b0);
      chk("rst_write_o", write_o, 1'b0);
      chk("rst_resp_o", resp_o, 1'b0);
      chk("rst_address_o", address_o, '0);
      chk("rst_burst_o", burst_o, '0);
      chk("rst_line_o", line_o, '0);
      tick();
      reset = 1'b0;
      tick();

      // Read, no gaps: completion lands BEATS+1 edges after the request cycle.
      read_i = 1'b1; address_i = 32'h1234_5678;
      line_q.push_back(LN_RD);
      t0 = cyc;
      tick();
      chk("rd_read_o", read_o, 1'b1);
      chk("rd_address_o", address_o, 32'h1234_5660);
      chk("rd_burst_o_zero", burst_o, '0);
      drive_read_beats(LN_RD);
      chk("rd_resp_o", resp_o, 1'b1);
      chk("rd_read_o_low", read_o, 1'b0);
      chk("rd_latency", cyc - t0, NB + 1);
      tick();
      read_i = 1'b0;
      chk("rd_resp_one_cycle", resp_o, 1'b0);
      chk("rd_line_hold", line_o, LN_RD);

      // Write with gaps 1,0,1,0,0,1,1.
      pat = '{1, 0, 1, 0, 0, 1, 1};
      write_i = 1'b1; address_i = 32'h0000_1004; line_i = LN_WR;
      for (int b = 0; b < NB; b++) beat_q.push_back(LN_WR[b*BW +: BW]);
      line_q.push_back(LN_WR);
      tick();
      chk("wr_address_o", address_o, 32'h0000_1000);
      for (int i = 0; i < 7; i++) begin
         chk("wr_write_o_held", write_o, 1'b1);
         resp_i = pat[i][0];
         tick();
      end
      resp_i = 1'b0;
      chk("wr_resp_o", resp_o, 1'b1);
      chk("wr_write_o_low", write_o, 1'b0);
      tick();
      write_i = 1'b0;
      chk("wr_resp_one_cycle", resp_o, 1'b0);

      // Simultaneous read and write: write first, held read follows.
      read_i = 1'b1; write_i = 1'b1; address_i = 32'hABCD_EF3F; line_i = LN_W2;
      for (int b = 0; b < NB; b++) beat_q.push_back(LN_W2[b*BW +: BW]);
      line_q.push_back(LN_W2);
      line_q.push_back(LN_R2);
      tick();
      chk("sim_write_first", {write_o, read_o}, 2'b10);
      chk("sim_address_o", address_o, 32'hABCD_EF20);
      resp_i = 1'b1;
      repeat (NB) tick();
      resp_i = 1'b0;
      chk("sim_wr_resp_o", resp_o, 1'b1);
      tick();
      write_i = 1'b0;
      chk("sim_idle_between", {resp_o, read_o, write_o}, 3'b000);
      tick();
      chk("sim_read_started", read_o, 1'b1);
      drive_read_beats(LN_R2);
      chk("sim_rd_resp_o", resp_o, 1'b1);
      tick();
      read_i = 1'b0;

      // Reset two beats into a read discards the partial line.
      read_i = 1'b1; address_i = 32'h0000_2000;
      tick();
      resp_i = 1'b1;
      burst_i = 64'h9999_9999_9999_9999; tick();
      burst_i = 64'h8888_8888_8888_8888; tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_read_o", read_o, 1'b0);
      chk("rst_mid_line_o", line_o, '0);
      chk("rst_mid_address_o", address_o, '0);
      resp_i = 1'b0; burst_i = '0; read_i = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      read_i = 1'b1; address_i = 32'h0000_2040;
      line_q.push_back(LN_FR);
      tick();
      drive_read_beats(LN_FR);
      chk("fresh_resp_o", resp_o, 1'b1);
      tick();
      read_i = 1'b0;

      // Stray acknowledges in IDLE must not touch buffer or counter.
      resp_i = 1'b1; burst_i = 64'hFFFF_0000_FFFF_0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stray_outputs", {read_o, write_o, resp_o}, 3'b000);
         chk("stray_line_o", line_o, LN_FR);
      end
      resp_i = 1'b0;
      read_i = 1'b1; address_i = 32'h0000_3000;
      line_q.push_back(LN_ST);
      tick();
      drive_read_beats(LN_ST);
      chk("stray_after_resp_o", resp_o, 1'b1);
      tick();
      read_i = 1'b0;

      // Other geometries run their own round trips.
      sweep_go = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (g_sw[0].done && g_sw[1].done) break;
         tick();
      end
      chk("sweep_done", {g_sw[0].done, g_sw[1].done}, 2'b11);

      chk("line_q_drained", line_q.size(), 0);
      chk("beat_q_drained", beat_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   for (genvar g = 0; g < 2; g++) begin : g_sw
      localparam int SLW = (g == 0) ? 512 : 128;
      localparam int SBW = (g == 0) ? 64 : 32;
      localparam int SNB = SLW / SBW;

      logic [SLW-1:0] s_line_i, s_line_o, mem_line, data;
      logic [SBW-1:0] s_burst_i, s_burst_o;
      logic [AW-1:0]  s_address_i, s_address_o;
      logic           s_read_i, s_write_i, s_resp_o, s_read_o, s_write_o, s_resp_i;
      bit             done = 1'b0;

      burst_line_adaptor #(.LINE_W(SLW), .BURST_W(SBW), .ADDR_W(AW)) dut_sw (
         .clk(clk), .reset(reset), .line_i(s_line_i), .line_o(s_line_o),
         .address_i(s_address_i), .read_i(s_read_i), .write_i(s_write_i), .resp_o(s_resp_o),
         .burst_i(s_burst_i), .burst_o(s_burst_o), .address_o(s_address_o),
         .read_o(s_read_o), .write_o(s_write_o), .resp_i(s_resp_i)
      );

      initial begin
         int  beat;
         logic [AW-1:0] a;
         s_line_i = '0; s_address_i = '0; s_read_i = 1'b0; s_write_i = 1'b0;
         s_burst_i = '0; s_resp_i = 1'b0; mem_line = '0;
         wait (sweep_go);
         for (int i = 0; i < SLW / 32; i++) data[i*32 +: 32] = $urandom();
         a = $urandom();

         // Write: memory model captures burst_o on each random acknowledge.
         s_write_i = 1'b1; s_address_i = a; s_line_i = data;
         tick();
         chk($sformatf("sw%0d_address_o", g), s_address_o, a & ~AW'((SLW / 8) - 1));
         beat = 0;
         for (int i = 0; i < 300; i++) begin
            if (s_resp_o) break;
            s_resp_i = 1'b0;
            if (s_write_o) begin
               s_resp_i = 1'($urandom_range(0, 1));
               if (s_resp_i && beat < SNB) begin
                  mem_line[beat*SBW +: SBW] = s_burst_o;
                  beat++;
               end
            end
            tick();
         end
         s_resp_i = 1'b0;
         chk($sformatf("sw%0d_wr_resp_o", g), s_resp_o, 1'b1);
         chk($sformatf("sw%0d_wr_beats", g), beat, SNB);
         chk($sformatf("sw%0d_mem_line", g), mem_line, data);
         tick();
         s_write_i = 1'b0;

         // Read back from the memory model with random gaps.
         s_read_i = 1'b1;
         tick();
         beat = 0;
         for (int i = 0; i < 300; i++) begin
            if (s_resp_o) break;
            s_resp_i = 1'b0;
            if (s_read_o) begin
               s_resp_i = 1'($urandom_range(0, 1));
               if (s_resp_i && beat < SNB) begin
                  s_burst_i = mem_line[beat*SBW +: SBW];
                  beat++;
               end
            end
            tick();
         end
         s_resp_i = 1'b0;
         chk($sformatf("sw%0d_rd_resp_o", g), s_resp_o, 1'b1);
         chk($sformatf("sw%0d_rd_line_o", g), s_line_o, data);
         tick();
         s_read_i = 1'b0;
         done = 1'b1;
      end
   end

endmodule
